// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART port.
// Status word layout and the write-data bit that acknowledges a received byte.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int ST_TXFULL  = 15;
    localparam int ST_TXIDLE  = 14;
    localparam int ST_RXVALID = 13;
    localparam int ST_OVERRUN = 12;

    localparam int ACK_BIT = 15;

    localparam int DEFAULT_BAUD_DIV   = 104;
    localparam int DEFAULT_FIFO_DEPTH = 8;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the TX byte buffer; first word is visible on rdata_o.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    assign rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_port.sv
// Memory-mapped UART: buffered 8N1 transmitter and single-byte receiver with overrun flag.
// Bus writes enqueue TX bytes or acknowledge RX; reads return the status word.
module uart_port
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] memOut,
    input  logic        memwrite,
    input  logic        uart,
    output logic [15:0] memIn,
    output logic        TX,
    input  logic        RX,
    output logic [1:0]  dbg_tx_state_o,
    output logic [1:0]  dbg_rx_state_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    logic       strobe, push, ack;
    logic [7:0] fifo_rdata;
    logic       fifo_full, fifo_empty, tx_pop;
    logic       unused_bits;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic          rx_stop_ok;
    logic          rxvalid_q, rxvalid_d, overrun_q, overrun_d;
    logic [7:0]    rxdata_q, rxdata_d;

    assign strobe      = memwrite & uart;
    assign push        = strobe & ~memOut[ACK_BIT];
    assign ack         = strobe & memOut[ACK_BIT];
    assign unused_bits = ^memOut[14:8];

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txfifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push),
        .wdata_i (memOut[7:0]),
        .pop_i   (tx_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_rdata;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_rdata;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // The pin is registered from the current state, so it lags the FSM by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (tx_state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_stop_ok = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_stop_ok = rx_sync2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A byte landing together with an ack replaces the old one and clears overrun.
    always_comb begin
        rxvalid_d = rxvalid_q;
        overrun_d = overrun_q;
        rxdata_d  = rxdata_q;
        if (ack) begin
            rxvalid_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (rx_stop_ok) begin
            if (ack || !rxvalid_q) begin
                rxdata_d  = rx_shift_q;
                rxvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rxvalid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            rxdata_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_sync1_q <= RX;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rxvalid_q  <= rxvalid_d;
            overrun_q  <= overrun_d;
            rxdata_q   <= rxdata_d;
        end
    end

    assign TX             = tx_q;
    assign memIn          = uart ? {fifo_full, fifo_empty & (tx_state_q == TX_IDLE),
                                    rxvalid_q, overrun_q, 4'h0, rxdata_q} : 16'h0000;
    assign dbg_tx_state_o = tx_state_q;
    assign dbg_rx_state_o = rx_state_q;

endmodule
